safety_sram_arbiter: RTL
========================

# safety_sram_arbiter

Two-requester arbiter for the single safety-island SRAM port, sitting between the SRAM macro and its two masters: the ECC memory controller (requester 0, functional traffic) and the fault-injection/BIST unit (requester 1). It gives each cycle's port access to one requester with round-robin fairness and supports locked sequences (read-modify-write). It provides an MBIST exclusive mode and routes read data back to the owner after a fixed SRAM latency. It flags starvation as a safety error for the error reporting unit.

## Interface
- AW, 32, SRAM address width
- DW, 64, SRAM data width (power of two, ≥8); strobe width DW/8
- RD_LAT, 1, SRAM read latency in cycles (1..4)
- STARVE_MAX, 64, cycles a request may wait before starvation error (≥2)

Ports:
- clk_i  in  1  safety clock; single clock domain
- rst_n_i  in  1  asynchronous, active-low reset
- mbist_en_i  in  1  requests BIST-exclusive mode (requester 1 only)
- rN_req_i  in  1  requester N (N=0,1) access request
- rN_we_i  in  1  1 = write, 0 = read
- rN_addr_i  in  AW  address
- rN_wdata_i  in  DW  write data
- rN_wstrb_i  in  DW/8  byte strobes
- rN_lock_i  in  1  keep ownership after this transfer
- rN_gnt_o  out  1  transfer accepted this cycle (req & gnt)
- rN_rvalid_o  out  1  read data valid for requester N
- rN_rdata_o  out  DW  read data (sram_rdata_i broadcast, qualified by rvalid)
- sram_req_o, sram_we_o  out  1  SRAM port strobe / write enable
- sram_addr_o  out  AW; sram_wdata_o  out  DW; sram_wstrb_o  out  DW/8
- sram_rdata_i  in  DW  SRAM read data, valid RD_LAT cycles after read strobe
- starve_err_o  out  1  one-cycle pulse on starvation
- starve_src_o  out  1  starved requester ID, valid with starve_err_o

## Operation
- States: RR, LOCK0, LOCK1, BIST.
- RR: a sole requester wins; on tie, the requester not in last_gnt wins. last_gnt updates on every accepted transfer.
- Accepted transfer with lock_i=1 from requester N -> LOCKN. In LOCKN only N is granted. An accepted N transfer with lock_i=0 -> RR, or BIST if mbist_en_i=1.
- mbist_en_i=1 in RR -> BIST next cycle. In LOCKN it is deferred until the lock releases. In BIST only requester 1 is granted, and r1_lock_i is ignored. mbist_en_i=0 -> RR next cycle.
- sram_* is a combinational mux of the granted requester. sram_req_o = any gnt. With no grant, sram_we_o, sram_addr_o, sram_wdata_o and sram_wstrb_o are 0.
- Read tracking: an RD_LAT-deep shift register of {valid, id} is loaded on each accepted read. Its output drives rN_rvalid_o for the matching id.
- Writes produce no response.
- Starvation: a per-requester counter increments each cycle req=1 & gnt=0. It clears on gnt or req=0, and holds (no increment) for requester 0 in BIST.
  - When a counter reaches STARVE_MAX: starve_err_o pulses for one cycle and the counter saturates.
  - No further pulse occurs until the counter clears. If both reach STARVE_MAX in the same cycle, report requester 0; requester 1 reports the next cycle.

## Timing
- Arbitration latency is 0 cycles: gnt_o is combinational from req and registered state.
- A request must hold stable until granted.
- Read data: rN_rvalid_o asserts exactly RD_LAT cycles after the accepting cycle. Back-to-back reads give one rvalid per cycle.
- State, last_gnt, the tracker and the counters are registered.
- Reset values:
  - state = RR; last_gnt = 1, so requester 0 wins the first tie.
  - All gnt, rvalid, sram_req_o and starve_err_o = 0; counters and tracker cleared.
- Reset mid-read: in-flight responses are discarded, and no rvalid follows reset release.
- A lock held while its owner drops req keeps ownership. The waiting requester then reaches starvation, which is intended detection.

## Structure
- Package safety_sram_pkg:
  - arb_state_e (RR, LOCK0, LOCK1, BIST)
  - req_id_t (1 bit)
  - constants REQ_ECC=0, REQ_BIST=1
- Sub-module safety_sram_rd_tracker: parameterised by RD_LAT, with inputs push/id and outputs valid/id. It holds the shift register.
- Arbiter FSM, mux and starvation counters stay in the top module.

## Test plan
- Both requesters read continuously out of reset -> grants alternate 0,1,0,1. Each rvalid lands RD_LAT cycles after its grant, on the correct requester.
- r0 write with lock=1, then r0 read with lock=0; r1 requesting throughout -> r1 gets no gnt until the cycle after r0's unlocked transfer, then wins.
- mbist_en_i=1 while r0 is in LOCK0 -> r0 finishes its unlocked transfer, then BIST entered. r0 not granted until mbist_en_i=0; r1 granted every cycle it requests.
- STARVE_MAX=8, r1 holds lock and idles, r0 requests -> starve_err_o pulses once with starve_src_o=0 exactly 8 cycles after r0's request. No second pulse.
- Reset asserted 1 cycle after an accepted read with RD_LAT=2 -> no rvalid after reset release; all outputs 0 during reset.
- Single requester r1 only, 16 back-to-back writes -> gnt every cycle, sram_* mirrors r1 inputs same cycle, starve_err_o never asserts.

Source files
------------

// File: rtl/safety_sram_pkg.sv
// Shared types and constants for the safety-island SRAM arbiter slice.
package safety_sram_pkg;

  typedef enum logic [1:0] {
    RR    = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2,
    BIST  = 2'd3
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_ECC  = 1'b0;
  localparam req_id_t REQ_BIST = 1'b1;

endpackage

// File: rtl/safety_sram_arbiter_if.sv
// Requester-side SRAM access bus: request/command from the master, grant and read response back.
interface safety_sram_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
);
  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            lock;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, wstrb, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/safety_sram_rd_tracker.sv
// Fixed-latency read tracker: shifts {valid, owner id} so read data is steered back RD_LAT cycles later.
module safety_sram_rd_tracker
  import safety_sram_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    push_i,
  input  req_id_t id_i,
  output logic    valid_o,
  output req_id_t id_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] id_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= push_i;
      id_q[0]    <= id_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign id_o    = id_q[RD_LAT-1];

endmodule

// File: rtl/safety_sram_arbiter.sv
// Two-requester round-robin arbiter for the safety-island SRAM port with lock,
// MBIST-exclusive mode, fixed-latency read steering and starvation detection.
module safety_sram_arbiter
  import safety_sram_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 64,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 mbist_en_i,
  safety_sram_arbiter_if.slave r0,
  safety_sram_arbiter_if.slave r1,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AW-1:0]        sram_addr_o,
  output logic [DW-1:0]        sram_wdata_o,
  output logic [DW/8-1:0]      sram_wstrb_o,
  input  logic [DW-1:0]        sram_rdata_i,
  output logic                 starve_err_o,
  output req_id_t              starve_src_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  arb_state_e state_q, state_d;
  req_id_t    last_gnt_q;
  logic       gnt0, gnt1;

  // Grant decode; grants are forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      RR: begin
        if (r0.req && r1.req) begin
          gnt0 = (last_gnt_q == REQ_BIST);
          gnt1 = (last_gnt_q == REQ_ECC);
        end else begin
          gnt0 = r0.req;
          gnt1 = r1.req;
        end
      end
      LOCK0:   gnt0 = r0.req;
      LOCK1:   gnt1 = r1.req;
      BIST:    gnt1 = r1.req;
      default: ;
    endcase
    if (!rst_n_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // A lock taken in RR outranks a simultaneous MBIST request; MBIST waits for release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RR: begin
        if (gnt0 && r0.lock)      state_d = LOCK0;
        else if (gnt1 && r1.lock) state_d = LOCK1;
        else if (mbist_en_i)      state_d = BIST;
      end
      LOCK0: if (gnt0 && !r0.lock) state_d = mbist_en_i ? BIST : RR;
      LOCK1: if (gnt1 && !r1.lock) state_d = mbist_en_i ? BIST : RR;
      BIST:  if (!mbist_en_i)      state_d = RR;
      default: state_d = RR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RR;
      last_gnt_q <= REQ_BIST;
    end else begin
      state_q <= state_d;
      if (gnt0)      last_gnt_q <= REQ_ECC;
      else if (gnt1) last_gnt_q <= REQ_BIST;
    end
  end

  always_comb begin
    sram_req_o   = gnt0 | gnt1;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wstrb_o = '0;
    if (gnt0) begin
      sram_we_o    = r0.we;
      sram_addr_o  = r0.addr;
      sram_wdata_o = r0.wdata;
      sram_wstrb_o = r0.wstrb;
    end else if (gnt1) begin
      sram_we_o    = r1.we;
      sram_addr_o  = r1.addr;
      sram_wdata_o = r1.wdata;
      sram_wstrb_o = r1.wstrb;
    end
  end

  logic    trk_valid;
  req_id_t trk_id;

  safety_sram_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (sram_req_o && !sram_we_o),
    .id_i    (gnt1 ? REQ_BIST : REQ_ECC),
    .valid_o (trk_valid),
    .id_o    (trk_id)
  );

  assign r0.gnt    = gnt0;
  assign r1.gnt    = gnt1;
  assign r0.rvalid = trk_valid && (trk_id == REQ_ECC);
  assign r1.rvalid = trk_valid && (trk_id == REQ_BIST);
  assign r0.rdata  = sram_rdata_i;
  assign r1.rdata  = sram_rdata_i;

  logic [CW-1:0] cnt_q [2];
  logic [1:0]    rep_q;
  logic [1:0]    req_v, gnt_v, hold_v, sat_v, report_v;

  assign req_v  = {r1.req, r0.req};
  assign gnt_v  = {gnt1, gnt0};
  assign hold_v = {1'b0, state_q == BIST};
  assign sat_v  = {cnt_q[1] == CNT_MAX, cnt_q[0] == CNT_MAX};

  // Requester 0 wins a same-cycle report; requester 1 stays unreported and goes next cycle.
  assign report_v[0] = sat_v[0] && !rep_q[0];
  assign report_v[1] = sat_v[1] && !rep_q[1] && !report_v[0];

  assign starve_err_o = |report_v;
  assign starve_src_o = report_v[1] ? REQ_BIST : REQ_ECC;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      rep_q    <= '0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        if (!req_v[n] || gnt_v[n]) begin
          cnt_q[n] <= '0;
          rep_q[n] <= 1'b0;
        end else begin
          if (!hold_v[n] && !sat_v[n]) cnt_q[n] <= cnt_q[n] + CW'(1);
          if (report_v[n])             rep_q[n] <= 1'b1;
        end
      end
    end
  end

endmodule
